// File: rtl/fir_xifu_scoreboard.sv
// In-order scoreboard for offloaded FIR XIF instructions: tracks in-flight entries,
// blocks issue on full/hazard, applies commit/kill, dispatches to EX, retires on WB.
module fir_xifu_scoreboard #(
  parameter int NB_ENTRIES = 4,
  parameter int ID_W       = 4,
  parameter int REG_AW     = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [ID_W-1:0]   issue_id_i,
  input  logic [REG_AW-1:0] issue_rs1_i,
  input  logic [REG_AW-1:0] issue_rs2_i,
  input  logic [1:0]        issue_rs_use_i,
  input  logic [REG_AW-1:0] issue_rd_i,
  input  logic              issue_rd_we_i,
  input  logic              commit_valid_i,
  input  logic [ID_W-1:0]   commit_id_i,
  input  logic              commit_kill_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [ID_W-1:0]   ex_id_o,
  input  logic              wb_done_i,
  input  logic [ID_W-1:0]   wb_done_id_i,
  output logic              full_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int PTR_W = $clog2(NB_ENTRIES);

  typedef enum logic [2:0] {FREE, ISSUED, COMMITTED, EXEC, KILLED} state_e;

  state_e            st     [NB_ENTRIES];
  logic [ID_W-1:0]   ent_id [NB_ENTRIES];
  logic [REG_AW-1:0] ent_rd [NB_ENTRIES];
  logic              ent_we [NB_ENTRIES];

  logic [PTR_W-1:0] head, dsp, tail;
  logic [PTR_W:0]   cnt;
  logic             err;

  logic             hazard, issue_fire;
  logic             cm_hit, cm_err;
  logic [PTR_W-1:0] cm_idx;
  logic             ex_fire, dsp_skip;
  logic             wb_ok, wb_err, auto_free, retire;

  // Hazard scan: every live (non-free, non-killed) writer blocks RAW and WAW,
  // including one that retires this very cycle.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NB_ENTRIES; i++) begin
      if (st[i] != FREE && st[i] != KILLED && ent_we[i]) begin
        if (issue_rs_use_i[0] && ent_rd[i] == issue_rs1_i) hazard = 1'b1;
        if (issue_rs_use_i[1] && ent_rd[i] == issue_rs2_i) hazard = 1'b1;
        if (issue_rd_we_i && ent_rd[i] == issue_rd_i)      hazard = 1'b1;
      end
    end
  end

  // Commit targets the oldest ISSUED entry carrying the id, scanning from head.
  always_comb begin
    cm_hit = 1'b0;
    cm_idx = '0;
    for (int k = 0; k < NB_ENTRIES; k++) begin
      if (!cm_hit && st[head + PTR_W'(k)] == ISSUED && ent_id[head + PTR_W'(k)] == commit_id_i) begin
        cm_hit = 1'b1;
        cm_idx = head + PTR_W'(k);
      end
    end
  end

  assign full_o        = (cnt == (PTR_W+1)'(NB_ENTRIES));
  assign busy_o        = (cnt != '0);
  assign err_o         = err;
  assign issue_ready_o = !full_o && !hazard;
  assign issue_fire    = issue_valid_i && issue_ready_o;
  assign cm_err        = commit_valid_i && !cm_hit;

  assign ex_valid_o = (st[dsp] == COMMITTED);
  assign ex_id_o    = ent_id[dsp];
  assign ex_fire    = ex_valid_o && ex_ready_i;
  assign dsp_skip   = (st[dsp] == KILLED);

  assign wb_ok     = wb_done_i && st[head] == EXEC && ent_id[head] == wb_done_id_i;
  assign wb_err    = wb_done_i && !wb_ok;
  assign auto_free = !wb_done_i && st[head] == KILLED;
  assign retire    = wb_ok || auto_free;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NB_ENTRIES; i++) st[i] <= FREE;
      head <= '0;
      dsp  <= '0;
      tail <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else if (clear_i) begin
      for (int i = 0; i < NB_ENTRIES; i++) st[i] <= FREE;
      head <= '0;
      dsp  <= '0;
      tail <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      // The updates below touch entries in mutually exclusive states, so they never collide.
      if (issue_fire) begin
        st[tail] <= ISSUED;
        tail     <= tail + 1'b1;
      end
      if (commit_valid_i && cm_hit) st[cm_idx] <= commit_kill_i ? KILLED : COMMITTED;
      if (ex_fire) begin
        st[dsp] <= EXEC;
        dsp     <= dsp + 1'b1;
      end else if (dsp_skip) begin
        dsp <= dsp + 1'b1;
      end
      if (retire) begin
        st[head] <= FREE;
        head     <= head + 1'b1;
      end
      case ({issue_fire, retire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (cm_err || wb_err) err <= 1'b1;
    end
  end

  // Payload fields are only meaningful while the entry state says so; no reset needed.
  always_ff @(posedge clk_i) begin
    if (issue_fire) begin
      ent_id[tail] <= issue_id_i;
      ent_rd[tail] <= issue_rd_i;
      ent_we[tail] <= issue_rd_we_i;
    end
  end

endmodule

// File: tb/tb_fir_xifu_scoreboard.sv
// Scoreboard bench: committed ids are queued in program order and popped as EX accepts them.
module tb_fir_xifu_scoreboard;
  localparam int NB_ENTRIES = 4;
  localparam int ID_W       = 4;
  localparam int REG_AW     = 5;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              clear_i = 1'b0;
  logic              issue_valid = 1'b0;
  logic              issue_ready;
  logic [ID_W-1:0]   issue_id = '0;
  logic [REG_AW-1:0] issue_rs1 = '0;
  logic [REG_AW-1:0] issue_rs2 = '0;
  logic [1:0]        issue_rs_use = '0;
  logic [REG_AW-1:0] issue_rd = '0;
  logic              issue_rd_we = 1'b0;
  logic              commit_valid = 1'b0;
  logic [ID_W-1:0]   commit_id = '0;
  logic              commit_kill = 1'b0;
  logic              ex_valid;
  logic              ex_ready = 1'b1;
  logic [ID_W-1:0]   ex_id;
  logic              wb_done = 1'b0;
  logic [ID_W-1:0]   wb_done_id = '0;
  logic              full, busy, err;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  fir_xifu_scoreboard #(.NB_ENTRIES(NB_ENTRIES), .ID_W(ID_W), .REG_AW(REG_AW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_id_i(issue_id),
    .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2), .issue_rs_use_i(issue_rs_use),
    .issue_rd_i(issue_rd), .issue_rd_we_i(issue_rd_we),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .ex_id_o(ex_id),
    .wb_done_i(wb_done), .wb_done_id_i(wb_done_id),
    .full_o(full), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int id, input int rs1, input int rs2, input int use_f,
                       input int rd, input int we, input int exp_rdy);
    issue_valid  = 1'b1;
    issue_id     = ID_W'(id);
    issue_rs1    = REG_AW'(rs1);
    issue_rs2    = REG_AW'(rs2);
    issue_rs_use = 2'(use_f);
    issue_rd     = REG_AW'(rd);
    issue_rd_we  = 1'(we);
    #1;
    chk("issue_ready", int'(issue_ready), exp_rdy);
  endtask

  task automatic issue(input int id, input int rs1, input int rs2, input int use_f,
                       input int rd, input int we);
    offer(id, rs1, rs2, use_f, rd, we, 1);
    step();
    issue_valid = 1'b0;
  endtask

  task automatic commit(input int id, input int kill);
    commit_valid = 1'b1;
    commit_id    = ID_W'(id);
    commit_kill  = 1'(kill);
    if (kill == 0) exp_q.push_back(id);
    step();
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
  endtask

  task automatic wb(input int id);
    wb_done    = 1'b1;
    wb_done_id = ID_W'(id);
    step();
    wb_done = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_ni && ex_valid && ex_ready) begin
      if (exp_q.size() == 0) chk("ex_unexpected", int'(ex_id), -1);
      else chk("ex_id_order", int'(ex_id), exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    rst_ni = 1'b1;
    step();
    chk("rst_issue_ready", int'(issue_ready), 1);
    chk("rst_ex_valid", int'(ex_valid), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);

    // Basic issue / commit / dispatch / retire with EX back-pressure
    ex_ready = 1'b0;
    issue(1, 0, 0, 0, 3, 1);
    chk("t1_busy", int'(busy), 1);
    chk("t1_no_ex_before_commit", int'(ex_valid), 0);
    commit(1, 0);
    chk("t1_ex_valid", int'(ex_valid), 1);
    chk("t1_ex_id", int'(ex_id), 1);
    step();
    chk("t1_ex_valid_hold", int'(ex_valid), 1);
    chk("t1_ex_id_hold", int'(ex_id), 1);
    ex_ready = 1'b1;
    step();
    chk("t1_ex_valid_after", int'(ex_valid), 0);
    wb(1);
    chk("t1_busy_end", int'(busy), 0);
    chk("t1_err", int'(err), 0);

    // RAW hazard blocks until the writer retires
    issue(2, 0, 0, 0, 3, 1);
    offer(3, 3, 0, 1, 5, 0, 0);
    step();
    chk("t2_not_taken_busy", int'(busy), 1);
    issue(3, 4, 0, 1, 5, 0);
    commit(2, 0);
    commit(3, 0);
    step();
    offer(4, 3, 0, 1, 6, 0, 0);
    offer(4, 0, 3, 2, 6, 0, 0);
    offer(4, 0, 0, 0, 3, 1, 0);
    issue_valid = 1'b0;
    wb(2);
    offer(4, 3, 0, 1, 6, 0, 1);
    issue_valid = 1'b0;
    wb(3);
    chk("t2_busy_end", int'(busy), 0);
    chk("t2_err", int'(err), 0);

    // Fill the table; a retire does not free a slot in the same cycle
    for (int i = 0; i < NB_ENTRIES; i++) begin
      chk("t3_full_before", int'(full), 0);
      issue(i, 0, 0, 0, 10 + i, 1);
    end
    chk("t3_full", int'(full), 1);
    offer(4, 0, 0, 0, 20, 1, 0);
    issue_valid = 1'b0;
    for (int i = 0; i < NB_ENTRIES; i++) commit(i, 0);
    step();
    step();
    wb_done    = 1'b1;
    wb_done_id = '0;
    offer(4, 0, 0, 0, 20, 1, 0);
    step();
    wb_done     = 1'b0;
    issue_valid = 1'b0;
    chk("t3_full_after_retire", int'(full), 0);
    chk("t3_busy", int'(busy), 1);
    for (int i = 1; i < NB_ENTRIES; i++) wb(i);
    chk("t3_busy_end", int'(busy), 0);
    chk("t3_err", int'(err), 0);

    // Kill in the middle: EX sees 0 then 2, killed entry auto-freed at head
    issue(0, 0, 0, 0, 1, 0);
    issue(1, 0, 0, 0, 2, 0);
    issue(2, 0, 0, 0, 3, 0);
    commit(1, 1);
    commit(0, 0);
    commit(2, 0);
    step();
    step();
    wb(0);
    step();
    chk("t4_busy_mid", int'(busy), 1);
    wb(2);
    chk("t4_busy_end", int'(busy), 0);
    chk("t4_err", int'(err), 0);

    // Unmatched commit sets sticky error; clear wipes everything
    issue(5, 0, 0, 0, 7, 0);
    commit_valid = 1'b1;
    commit_id    = 4'd7;
    step();
    commit_valid = 1'b0;
    chk("t5_err_set", int'(err), 1);
    step();
    chk("t5_err_held", int'(err), 1);
    chk("t5_busy_before_clear", int'(busy), 1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("t5_err_cleared", int'(err), 0);
    chk("t5_busy_cleared", int'(busy), 0);

    // Async reset mid-operation
    ex_ready = 1'b0;
    issue(8, 0, 0, 0, 1, 0);
    issue(9, 0, 0, 0, 2, 0);
    issue(10, 0, 0, 0, 3, 0);
    commit(8, 0);
    chk("t6_ex_valid_pre", int'(ex_valid), 1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("t6_ex_valid_rst", int'(ex_valid), 0);
    chk("t6_busy_rst", int'(busy), 0);
    chk("t6_ready_rst", int'(issue_ready), 1);
    exp_q.delete();
    rst_ni = 1'b1;
    step();
    chk("t6_ex_valid_after", int'(ex_valid), 0);
    chk("t6_busy_after", int'(busy), 0);
    ex_ready = 1'b1;

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
